// File: rtl/trap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_pkg                                                               |
// | Shared types and constants for the trap controller.                   |
// | Rev 1.0 - initial release                                              |
// +----------------------------------------------------------------------+
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } trap_state_t;

    localparam logic [1:0] VEC_DIRECT     = 2'd0;
    localparam logic [1:0] VEC_VECTORED   = 2'd1;
    localparam int         MCAUSE_INT_BIT = 31;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_prio_enc                                                          |
// | Priority encoder, LSB-first or MSB-first, with valid flag.            |
// | Rev 1.0 - initial release                                              |
// +----------------------------------------------------------------------+
module trap_prio_enc #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = 2
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // The last match in scan order wins, so scan towards the winning end.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (MSB_FIRST) begin
                if (i_req[i]) o_idx = IDX_W'(i);
            end else begin
                if (i_req[N-1-i]) o_idx = IDX_W'(N - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_ctrl                                                              |
// | Arbitrates exceptions and interrupts, holds the trap until ACK.       |
// | Rev 1.0 - initial release                                              |
// +----------------------------------------------------------------------+
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int STAGES    = 6,
    parameter int EXC_SRCS  = 2,
    parameter int INT_LINES = 16,
    parameter int HOLDOFF   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    input  logic                   MEM_WAIT,
    input  logic [STAGES*32-1:0]   STAGE_PC,
    input  logic [EXC_SRCS-1:0]    EXC_EN,
    input  logic [EXC_SRCS*4-1:0]  EXC_CODE,
    input  logic [EXC_SRCS*32-1:0] EXC_PC,
    input  logic                   INT_ALLOW,
    input  logic [INT_LINES-1:0]   INT_PEND,
    input  logic [INT_LINES-1:0]   INT_MASK,
    input  logic [1:0]             TRAP_VEC_MODE,
    input  logic [31:0]            TRAP_VEC_BASE,
    input  logic                   TRAP_ACK,
    output logic                   TRAP_EN,
    output logic [31:0]            TRAP_PC,
    output logic [31:0]            TRAP_CODE,
    output logic [31:0]            TRAP_JMP_TO,
    output logic                   TRAP_BUSY
);

    localparam int c_CODE_W    = (clog2(INT_LINES) < 4) ? 4 : clog2(INT_LINES);
    localparam int c_EXC_IDX_W = (clog2(EXC_SRCS) < 1) ? 1 : clog2(EXC_SRCS);
    localparam int c_CNT_W     = (clog2(HOLDOFF + 1) < 1) ? 1 : clog2(HOLDOFF + 1);
    localparam int c_CAP_W     = STAGES*32 + EXC_SRCS*37 + 1 + 2*INT_LINES + 2 + 30;

    trap_state_t r_state, w_state_nxt;

    logic [c_CAP_W-1:0]     r_cap;
    logic [c_CAP_W-1:0]     w_cap_in;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [31:0]            r_trap_pc, r_trap_code, r_trap_jmp;

    logic [STAGES*32-1:0]   w_cap_stage_pc;
    logic [EXC_SRCS-1:0]    w_cap_exc_en;
    logic [EXC_SRCS*4-1:0]  w_cap_exc_code;
    logic [EXC_SRCS*32-1:0] w_cap_exc_pc;
    logic                   w_cap_allow;
    logic [INT_LINES-1:0]   w_cap_pend, w_cap_mask;
    logic [1:0]             w_cap_mode;
    logic [29:0]            w_cap_base;

    logic                   w_exc_valid, w_int_valid, w_sel;
    logic [c_EXC_IDX_W-1:0] w_exc_idx;
    logic [c_CODE_W-1:0]    w_int_idx;
    logic [31:0]            w_base, w_oldest_pc, w_pc, w_code, w_jmp;
    logic                   w_unused_base;

    // mtvec alignment bits are architecturally ignored.
    assign w_unused_base = ^TRAP_VEC_BASE[1:0];

    assign w_cap_in = {STAGE_PC, EXC_EN, EXC_CODE, EXC_PC, INT_ALLOW, INT_PEND,
                       INT_MASK, TRAP_VEC_MODE, TRAP_VEC_BASE[31:2]};
    assign {w_cap_stage_pc, w_cap_exc_en, w_cap_exc_code, w_cap_exc_pc, w_cap_allow,
            w_cap_pend, w_cap_mask, w_cap_mode, w_cap_base} = r_cap;

    trap_prio_enc #(
        .N         (EXC_SRCS),
        .MSB_FIRST (1'b0),
        .IDX_W     (c_EXC_IDX_W)
    ) u_exc_enc (
        .i_req   (w_cap_exc_en),
        .o_valid (w_exc_valid),
        .o_idx   (w_exc_idx)
    );

    trap_prio_enc #(
        .N         (INT_LINES),
        .MSB_FIRST (1'b1),
        .IDX_W     (c_CODE_W)
    ) u_int_enc (
        .i_req   (w_cap_pend & w_cap_mask & {INT_LINES{w_cap_allow}}),
        .o_valid (w_int_valid),
        .o_idx   (w_int_idx)
    );

    assign w_sel  = w_exc_valid | w_int_valid;
    assign w_base = {w_cap_base, 2'b00};

    // Highest-index nonzero stage is the oldest instruction still in flight.
    always_comb begin
        w_oldest_pc = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (w_cap_stage_pc[i*32 +: 32] != 32'd0) w_oldest_pc = w_cap_stage_pc[i*32 +: 32];
        end
    end

    always_comb begin
        w_pc   = '0;
        w_code = '0;
        w_jmp  = w_base;
        if (w_exc_valid) begin
            w_pc   = w_cap_exc_pc[int'(w_exc_idx)*32 +: 32];
            w_code = {28'd0, w_cap_exc_code[int'(w_exc_idx)*4 +: 4]};
        end else if (w_int_valid) begin
            w_pc                   = w_oldest_pc;
            w_code                 = 32'(w_int_idx);
            w_code[MCAUSE_INT_BIT] = 1'b1;
            case (w_cap_mode)
                VEC_VECTORED: w_jmp = w_base + (32'(w_int_idx) << 2);
                VEC_DIRECT:   w_jmp = w_base;
                default:      w_jmp = w_base;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_sel && !MEM_WAIT) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (TRAP_ACK) w_state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (!MEM_WAIT && r_cnt <= c_CNT_W'(1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cap       <= '0;
            r_cnt       <= '0;
            r_trap_pc   <= '0;
            r_trap_code <= '0;
            r_trap_jmp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (FLUSH)          r_cap <= '0;
                    else if (!MEM_WAIT) r_cap <= w_cap_in;
                    if (w_state_nxt == ST_ISSUE) begin
                        r_trap_pc   <= w_pc;
                        r_trap_code <= w_code;
                        r_trap_jmp  <= w_jmp;
                    end
                end
                ST_ISSUE: begin
                    if (TRAP_ACK) begin
                        r_cap       <= '0;
                        r_cnt       <= c_CNT_W'(HOLDOFF);
                        r_trap_pc   <= '0;
                        r_trap_code <= '0;
                        r_trap_jmp  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!MEM_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign TRAP_EN     = (r_state == ST_ISSUE);
    assign TRAP_BUSY   = (r_state != ST_IDLE);
    assign TRAP_PC     = r_trap_pc;
    assign TRAP_CODE   = r_trap_code;
    assign TRAP_JMP_TO = r_trap_jmp;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trap_ctrl                                                           |
// | Directed vector bench for trap_ctrl.                                  |
// | Rev 1.0 - initial release                                              |
// +----------------------------------------------------------------------+
module tb_trap_ctrl;

    localparam int STAGES    = 6;
    localparam int EXC_SRCS  = 2;
    localparam int INT_LINES = 16;
    localparam int HOLDOFF   = 4;

    logic                   CLK = 1'b0;
    logic                   RST, FLUSH, MEM_WAIT, INT_ALLOW, TRAP_ACK;
    logic [STAGES*32-1:0]   STAGE_PC;
    logic [EXC_SRCS-1:0]    EXC_EN;
    logic [EXC_SRCS*4-1:0]  EXC_CODE;
    logic [EXC_SRCS*32-1:0] EXC_PC;
    logic [INT_LINES-1:0]   INT_PEND, INT_MASK;
    logic [1:0]             TRAP_VEC_MODE;
    logic [31:0]            TRAP_VEC_BASE;
    logic                   TRAP_EN, TRAP_BUSY;
    logic [31:0]            TRAP_PC, TRAP_CODE, TRAP_JMP_TO;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    trap_ctrl #(
        .STAGES    (STAGES),
        .EXC_SRCS  (EXC_SRCS),
        .INT_LINES (INT_LINES),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .FLUSH         (FLUSH),
        .MEM_WAIT      (MEM_WAIT),
        .STAGE_PC      (STAGE_PC),
        .EXC_EN        (EXC_EN),
        .EXC_CODE      (EXC_CODE),
        .EXC_PC        (EXC_PC),
        .INT_ALLOW     (INT_ALLOW),
        .INT_PEND      (INT_PEND),
        .INT_MASK      (INT_MASK),
        .TRAP_VEC_MODE (TRAP_VEC_MODE),
        .TRAP_VEC_BASE (TRAP_VEC_BASE),
        .TRAP_ACK      (TRAP_ACK),
        .TRAP_EN       (TRAP_EN),
        .TRAP_PC       (TRAP_PC),
        .TRAP_CODE     (TRAP_CODE),
        .TRAP_JMP_TO   (TRAP_JMP_TO),
        .TRAP_BUSY     (TRAP_BUSY)
    );

    typedef struct {
        string        name;
        logic [1:0]   exc_en;
        logic [7:0]   exc_code;
        logic [63:0]  exc_pc;
        logic         allow;
        logic [15:0]  pend;
        logic [15:0]  mask;
        logic [1:0]   mode;
        logic [31:0]  base;
        logic [191:0] stage_pc;
        logic         exp_en;
        logic [31:0]  exp_pc;
        logic [31:0]  exp_code;
        logic [31:0]  exp_jmp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        FLUSH         = 1'b0;
        MEM_WAIT      = 1'b0;
        INT_ALLOW     = 1'b0;
        TRAP_ACK      = 1'b0;
        STAGE_PC      = '0;
        EXC_EN        = '0;
        EXC_CODE      = '0;
        EXC_PC        = '0;
        INT_PEND      = '0;
        INT_MASK      = '0;
        TRAP_VEC_MODE = '0;
        TRAP_VEC_BASE = '0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (TRAP_BUSY !== 1'b0 && k < 30) begin
            tick();
            k++;
        end
        chk({name, "/drain_done"}, 32'(TRAP_BUSY), 32'd0);
    endtask

    // Inputs live for one cycle (n); trap expected from cycle n+2.
    task automatic apply_vec(input vec_t v);
        EXC_EN        = v.exc_en;
        EXC_CODE      = v.exc_code;
        EXC_PC        = v.exc_pc;
        INT_ALLOW     = v.allow;
        INT_PEND      = v.pend;
        INT_MASK      = v.mask;
        TRAP_VEC_MODE = v.mode;
        TRAP_VEC_BASE = v.base;
        STAGE_PC      = v.stage_pc;
        tick();
        clear_inputs();
        chk({v.name, "/en_n1"}, 32'(TRAP_EN), 32'd0);
        tick();
        chk({v.name, "/en_n2"}, 32'(TRAP_EN), 32'(v.exp_en));
        chk({v.name, "/busy"}, 32'(TRAP_BUSY), 32'(v.exp_en));
        chk({v.name, "/pc"}, TRAP_PC, v.exp_pc);
        chk({v.name, "/code"}, TRAP_CODE, v.exp_code);
        chk({v.name, "/jmp"}, TRAP_JMP_TO, v.exp_jmp);
        if (v.exp_en) begin
            TRAP_ACK = 1'b1;
            tick();
            TRAP_ACK = 1'b0;
            chk({v.name, "/en_after_ack"}, 32'(TRAP_EN), 32'd0);
            chk({v.name, "/pc_after_ack"}, TRAP_PC, 32'd0);
            chk({v.name, "/busy_drain"}, 32'(TRAP_BUSY), 32'd1);
            wait_idle(v.name);
        end else begin
            tick();
            chk({v.name, "/en_n3"}, 32'(TRAP_EN), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;

        vecs[0] = '{"exc_direct", 2'b10, 8'h20, {32'h80, 32'h0}, 1'b0, 16'h0, 16'h0, 2'd0,
                    32'h1000, 192'h0, 1'b1, 32'h80, 32'h2, 32'h1000};
        vecs[1] = '{"int_vectored", 2'b00, 8'h00, 64'h0, 1'b1, 16'h0800, 16'h0800, 2'd1,
                    32'h1001, {32'h0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h10},
                    1'b1, 32'h40, 32'h8000000B, 32'h102C};
        vecs[2] = '{"simultaneous", 2'b11, 8'h75, {32'h200, 32'h100}, 1'b1, 16'h0008, 16'h0008,
                    2'd1, 32'h2000, 192'h0, 1'b1, 32'h100, 32'h5, 32'h2000};
        vecs[3] = '{"mask_zero", 2'b00, 8'h00, 64'h0, 1'b1, 16'hFFFF, 16'h0000, 2'd0,
                    32'h1000, 192'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{"allow_zero", 2'b00, 8'h00, 64'h0, 1'b0, 16'hFFFF, 16'hFFFF, 2'd0,
                    32'h1000, 192'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[5] = '{"int_multi_direct", 2'b00, 8'h00, 64'h0, 1'b1, 16'h00F0, 16'h0FF0, 2'd0,
                    32'h3003, 192'h0, 1'b1, 32'h0, 32'h80000007, 32'h3000};
        vecs[6] = '{"int_mode2", 2'b00, 8'h00, 64'h0, 1'b1, 16'h8000, 16'h8000, 2'd2,
                    32'h4000, {32'h500, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4},
                    1'b1, 32'h500, 32'h8000000F, 32'h4000};
        vecs[7] = '{"int_vec_wrap", 2'b00, 8'h00, 64'h0, 1'b1, 16'h8000, 16'h8000, 2'd1,
                    32'hFFFFFFFF, {32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'h0},
                    1'b1, 32'h8, 32'h8000000F, 32'h38};
        vecs[8] = '{"exc_src0_vecmode", 2'b01, 8'h0F, {32'h0, 32'hDEADBEE0}, 1'b0, 16'h0, 16'h0,
                    2'd1, 32'h100, 192'h0, 1'b1, 32'hDEADBEE0, 32'hF, 32'h100};

        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        chk("reset/en", 32'(TRAP_EN), 32'd0);
        chk("reset/busy", 32'(TRAP_BUSY), 32'd0);
        chk("reset/pc", TRAP_PC, 32'd0);
        chk("reset/code", TRAP_CODE, 32'd0);
        chk("reset/jmp", TRAP_JMP_TO, 32'd0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Hold-off with MEM_WAIT stretching the drain window by three cycles.
        INT_ALLOW     = 1'b1;
        INT_PEND      = 16'h0004;
        INT_MASK      = 16'h0004;
        TRAP_VEC_BASE = 32'h100;
        k = 0;
        while (TRAP_EN !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("holdoff/first_latency", 32'(k), 32'd2);
        chk("holdoff/first_code", TRAP_CODE, 32'h80000002);
        TRAP_ACK = 1'b1;
        tick();
        TRAP_ACK = 1'b0;
        MEM_WAIT = 1'b1;
        chk("holdoff/pulse_en", 32'(TRAP_EN), 32'd0);
        chk("holdoff/pulse_busy", 32'(TRAP_BUSY), 32'd1);
        tick();
        tick();
        tick();
        MEM_WAIT = 1'b0;
        k = 4;
        while (TRAP_EN !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk("holdoff/retrap_distance", 32'(k), 32'd10);
        chk("holdoff/second_code", TRAP_CODE, 32'h80000002);
        chk("holdoff/second_jmp", TRAP_JMP_TO, 32'h100);
        clear_inputs();
        TRAP_ACK = 1'b1;
        tick();
        TRAP_ACK = 1'b0;
        wait_idle("holdoff");
        tick();

        // FLUSH in the capture cycle discards the exception.
        EXC_EN   = 2'b01;
        EXC_CODE = 8'h03;
        EXC_PC   = 64'h44;
        FLUSH    = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("flush/en_n2", 32'(TRAP_EN), 32'd0);
        tick();
        chk("flush/en_n3", 32'(TRAP_EN), 32'd0);
        chk("flush/busy", 32'(TRAP_BUSY), 32'd0);

        // MEM_WAIT in IDLE blocks capture; a stray ACK has no effect.
        EXC_EN   = 2'b01;
        EXC_CODE = 8'h06;
        EXC_PC   = 64'h60;
        MEM_WAIT = 1'b1;
        TRAP_ACK = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("memwait_idle/en_n2", 32'(TRAP_EN), 32'd0);
        chk("memwait_idle/busy", 32'(TRAP_BUSY), 32'd0);

        // RST while a trap is being issued.
        EXC_EN        = 2'b01;
        EXC_CODE      = 8'h04;
        EXC_PC        = 64'h88;
        TRAP_VEC_BASE = 32'h500;
        tick();
        clear_inputs();
        tick();
        chk("rst_issue/en_before", 32'(TRAP_EN), 32'd1);
        chk("rst_issue/code_before", TRAP_CODE, 32'h4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_issue/en", 32'(TRAP_EN), 32'd0);
        chk("rst_issue/busy", 32'(TRAP_BUSY), 32'd0);
        chk("rst_issue/pc", TRAP_PC, 32'd0);
        chk("rst_issue/code", TRAP_CODE, 32'd0);
        chk("rst_issue/jmp", TRAP_JMP_TO, 32'd0);
        tick();
        tick();
        chk("rst_issue/no_retrap", 32'(TRAP_EN), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
